// File: rtl/riscv_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pc_unit
// Description : Program counter with prioritised redirects (trap > mret >
//               jump > branch), a one-entry pending-redirect slot for stalls,
//               and jump/branch target alignment fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_pc_unit #(
    parameter int                          WORD_LENGTH  = 32,
    parameter int                          PC_OFFSET    = 4,
    parameter logic [WORD_LENGTH-1:0]      RESET_VECTOR = '0,
    parameter int                          IALIGN       = 4,   // 2 or 4
    parameter int                          PC_SEL_WIDTH = 2,
    parameter logic [PC_SEL_WIDTH-1:0]     PC_ALU       = PC_SEL_WIDTH'(1),
    parameter logic [PC_SEL_WIDTH-1:0]     PC_B_TARGET  = PC_SEL_WIDTH'(2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [WORD_LENGTH-1:0]  alu_out,
    input  logic [WORD_LENGTH-1:0]  imm_b_sext,
    input  logic                    br_flag,
    input  logic                    trap_req,
    input  logic [WORD_LENGTH-1:0]  trap_vec,
    input  logic                    mret_req,
    input  logic [WORD_LENGTH-1:0]  mepc,
    output logic [WORD_LENGTH-1:0]  pc_out,
    output logic [WORD_LENGTH-1:0]  pc_plus4,
    output logic                    fetch_valid,
    output logic                    redirect_pending,
    output logic                    misalign_flag,
    output logic [WORD_LENGTH-1:0]  misalign_addr
);

    localparam logic [WORD_LENGTH-1:0] c_PC_INC     = WORD_LENGTH'(PC_OFFSET);
    localparam logic [WORD_LENGTH-1:0] c_ALIGN_MASK = WORD_LENGTH'(IALIGN - 1);
    localparam logic [WORD_LENGTH-1:0] c_TRAP_MASK  = ~WORD_LENGTH'(3);

    // Redirect priority classes; larger value wins.
    localparam logic [1:0] c_CLS_BR   = 2'd0;
    localparam logic [1:0] c_CLS_JMP  = 2'd1;
    localparam logic [1:0] c_CLS_MRET = 2'd2;
    localparam logic [1:0] c_CLS_TRAP = 2'd3;

    logic [WORD_LENGTH-1:0] r_pc;
    logic [WORD_LENGTH-1:0] r_pend_tgt;
    logic [1:0]             r_pend_cls;
    logic                   r_pend_valid;
    logic                   r_fetch_valid;
    logic                   r_misalign_flag;
    logic [WORD_LENGTH-1:0] r_misalign_addr;

    logic [WORD_LENGTH-1:0] w_pc_plus;
    logic                   w_live_valid;
    logic                   w_live_chk;
    logic [1:0]             w_live_cls;
    logic [WORD_LENGTH-1:0] w_live_tgt;
    logic                   w_misalign;
    logic                   w_live_wins;

    assign w_pc_plus = r_pc + c_PC_INC;

    always_comb begin
        w_live_valid = 1'b0;
        w_live_chk   = 1'b0;
        w_live_cls   = c_CLS_BR;
        w_live_tgt   = w_pc_plus;
        if (trap_req) begin
            // Direct mode only: the mtvec mode bits are dropped.
            w_live_valid = 1'b1;
            w_live_cls   = c_CLS_TRAP;
            w_live_tgt   = trap_vec & c_TRAP_MASK;
        end else if (mret_req) begin
            w_live_valid = 1'b1;
            w_live_cls   = c_CLS_MRET;
            w_live_tgt   = mepc;
        end else if (pc_sel == PC_ALU) begin
            w_live_valid = 1'b1;
            w_live_chk   = 1'b1;
            w_live_cls   = c_CLS_JMP;
            w_live_tgt   = alu_out;
        end else if ((pc_sel == PC_B_TARGET) && br_flag) begin
            w_live_valid = 1'b1;
            w_live_chk   = 1'b1;
            w_live_cls   = c_CLS_BR;
            w_live_tgt   = r_pc + imm_b_sext;
        end
    end

    assign w_misalign  = w_live_chk && (|(w_live_tgt & c_ALIGN_MASK));
    // Live redirect beats the pending slot on ties, both when capturing and when resolving.
    assign w_live_wins = w_live_valid && !w_misalign
                         && (!r_pend_valid || (w_live_cls >= r_pend_cls));

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_pc            <= RESET_VECTOR;
            r_pend_tgt      <= '0;
            r_pend_cls      <= c_CLS_BR;
            r_pend_valid    <= 1'b0;
            r_fetch_valid   <= 1'b0;
            r_misalign_flag <= 1'b0;
            r_misalign_addr <= '0;
        end else if (!r_fetch_valid) begin
            r_fetch_valid <= 1'b1;
            r_pc          <= RESET_VECTOR;
        end else begin
            r_misalign_flag <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= w_live_tgt;
            end
            if (stall) begin
                if (w_live_wins) begin
                    r_pend_valid <= 1'b1;
                    r_pend_tgt   <= w_live_tgt;
                    r_pend_cls   <= w_live_cls;
                end
            end else begin
                r_pend_valid <= 1'b0;
                if (w_live_wins) begin
                    r_pc <= w_live_tgt;
                end else if (r_pend_valid) begin
                    r_pc <= r_pend_tgt;
                end else if (!w_misalign) begin
                    r_pc <= w_pc_plus;
                end
            end
        end
    end

    assign pc_out           = r_pc;
    assign pc_plus4         = w_pc_plus;
    assign fetch_valid      = r_fetch_valid;
    assign redirect_pending = r_pend_valid;
    assign misalign_flag    = r_misalign_flag;
    assign misalign_addr    = r_misalign_addr;

endmodule
`default_nettype wire

// File: doc/riscv_pc_unit.md
Name: riscv_pc_unit

Overview:
Parametrised program-counter unit, successor to the core's single-cycle PC register. It adds prioritised redirect sources (trap, mret, jump, branch), stall handling with a one-entry pending-redirect slot, and target-alignment checking with a fault report. It sits between the decode/execute/CSR logic, which supplies redirects, and instruction memory, which consumes pc_out.

Parameters:
WORD_LENGTH, 32, width of PC and all address ports
PC_OFFSET, 4, sequential increment
RESET_VECTOR, 32'h0000_0000, PC value while reset is high and right after release
IALIGN, 4, required target alignment in bytes; legal values are 2 and 4

Ports:
clk  input  1  core clock; state updates on the falling edge, matching the core's PC timing
reset  input  1  asynchronous, active-high
stall  input  1  hold PC this edge (hazard or imem not ready)
pc_sel  input  PC_SEL  PC_ALU = jump; PC_B_TARGET = conditional branch; any other value = sequential
alu_out  input  WORD_LENGTH  jump target
imm_b_sext  input  WORD_LENGTH  sign-extended branch offset
br_flag  input  1  branch taken
trap_req  input  1  exception/interrupt redirect request
trap_vec  input  WORD_LENGTH  mtvec value
mret_req  input  1  return-from-trap request
mepc  input  WORD_LENGTH  return address
pc_out  output  WORD_LENGTH  current PC
pc_plus4  output  WORD_LENGTH  pc_out + PC_OFFSET, combinational
fetch_valid  output  1  pc_out is a valid fetch address
redirect_pending  output  1  pending slot occupied
misalign_flag  output  1  one-cycle pulse: rejected misaligned jump/branch
misalign_addr  output  WORD_LENGTH  offending target, held until the next fault

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_VECTOR
  - fetch_valid = 0, redirect_pending = 0, misalign_flag = 0, misalign_addr = 0
- fetch_valid becomes 1 on the first falling edge after reset deasserts and stays 1. That same edge loads RESET_VECTOR again; it does not advance the PC.
- Live redirect candidates, highest priority first:
  - trap_req: target = {trap_vec[W-1:2], 2'b00}; direct mode only, mode bits discarded
  - mret_req: target = mepc
  - pc_sel == PC_ALU: target = alu_out
  - pc_sel == PC_B_TARGET with br_flag=1: target = pc + imm_b_sext
  - Otherwise there is no redirect and the next PC is pc + PC_OFFSET.
- All adds are modulo 2^WORD_LENGTH; 0xFFFFFFFC + 4 wraps to 0.
- Alignment check:
  - Applies to jump and branch targets only. Trap and mret targets are trusted and never checked.
  - Misaligned when target % IALIGN != 0.
  - A misaligned target is discarded. On that edge pc holds, misalign_flag pulses for one cycle and misalign_addr takes the target.
  - A misaligned target is never written into the pending slot.
- Stall edge (stall=1):
  - pc holds.
  - If a live aligned redirect exists, it is written to the pending slot together with its priority class, and redirect_pending = 1.
  - A later stalled redirect of equal or higher priority overwrites the slot. A lower-priority one is dropped.
  - Branch targets are computed from the current pc at capture time.
- Non-stall edge:
  - The winner is the higher-priority of the pending entry and the live redirect; the live redirect wins ties.
  - pc takes the winning target, or pc + PC_OFFSET if neither exists. The slot clears.
  - A misaligned live redirect on this edge raises the fault. If a pending entry exists, pc still takes the pending target.
- Reset asserted mid-stall discards the pending entry.
- trap_req and mret_req on the same edge: trap wins and mret is dropped.
- Implementation uses one registered state: pc, pending target, pending class (2 bits), fetch_valid, misalign regs. No other storage.

Test Plan:
1. Assert reset asynchronously mid-cycle -> pc_out = 0 immediately and fetch_valid = 0. Release -> first edge pc = 0 with fetch_valid = 1; following edges give 4, 8, 12.
2. pc=0x10, pc_sel=PC_B_TARGET, imm_b_sext=0x20, br_flag=1 -> pc 0x30. Repeat with br_flag=0 -> pc 0x14. imm_b_sext=0xFFFFFFF0 from 0x30 -> 0x20.
3. pc=0x14, stall=1 with PC_ALU/alu_out=0x100 for one edge, then stall=1 with no redirect -> pc holds 0x14, redirect_pending = 1. Release stall -> pc 0x100, redirect_pending = 0. Variant: trap (trap_vec=0x203) during stall after the jump -> release gives 0x200.
4. Same edge: trap_req=1 with trap_vec=0x83, mret_req=1, PC_ALU with 0x400 -> pc 0x80. Same edge with only mret (mepc=0x44) and jump -> pc 0x44.
5. IALIGN=4, alu_out=0x102 -> pc holds, misalign_flag high for exactly one cycle, misalign_addr = 0x102. IALIGN=2 build: 0x102 is accepted, 0x101 faults.
6. pc=0xFFFFFFFC with no redirect -> pc_plus4 = 0 and next pc = 0. Assert reset while redirect_pending = 1 -> pc = RESET_VECTOR and pending is lost after release.
